// File: rtl/regfile_wb_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package regfile_wb_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned NREG_DEF   = 32;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned NREG_W_DEF = $clog2(NREG_DEF);

    // One pending register write: destination and value.
    typedef struct packed {
        logic [NREG_W_DEF-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// wb_fifo: Depth-entry FIFO of writeback entries (Depth a power of two).
// The storage array, read pointer and count are exposed so the owner can
// search pending writes without popping them.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter type entry_t = wb_entry_t,
    parameter int unsigned Depth = DEPTH_DEF,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  entry_t                  push_data_i,
    input  logic                    pop_i,
    output entry_t                  head_o,
    output logic                    empty_o,
    output logic                    full_o,
    output entry_t [Depth-1:0]      entries_o,
    output logic   [PtrW-1:0]       rd_ptr_o,
    output logic   [CntW-1:0]       count_o
);

    entry_t [Depth-1:0] mem_q, mem_d;
    logic   [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic   [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic   [CntW-1:0]  count_q, count_d;
    logic               push_ok, pop_ok;

    // Status and read-side views come straight from registered state.
    always_comb begin
        empty_o   = (count_q == '0);
        full_o    = (count_q == CntW'(Depth));
        head_o    = mem_q[rd_ptr_q];
        entries_o = mem_q;
        rd_ptr_o  = rd_ptr_q;
        count_o   = count_q;
    end

    // Next-state: pointers wrap naturally because Depth is a power of two.
    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    // State register; reset empties the queue immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges LSU and ALU writebacks into one regfile write
// port through a pending-write queue; a debug write overrides the port.
// Optional pending-write bypass search is built when WB_BYPASS_EN is defined.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned XLen  = XLEN_DEF,
    parameter int unsigned NReg  = NREG_DEF,
    parameter int unsigned Depth = DEPTH_DEF,
    localparam int unsigned NRegWidth = $clog2(NReg)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [NRegWidth-1:0] lsu_rd_i,
    input  logic [XLen-1:0]      lsu_data_i,
    input  logic                 alu_valid_i,
    output logic                 alu_ready_o,
    input  logic [NRegWidth-1:0] alu_rd_i,
    input  logic [XLen-1:0]      alu_data_i,
    input  logic                 dbg_we_i,
    input  logic [NRegWidth-1:0] dbg_addr_i,
    input  logic [XLen-1:0]      dbg_data_i,
    output logic [NRegWidth-1:0] a3_o,
    output logic                 we3_o,
    output logic [XLen-1:0]      wd3_o,
    input  logic [NRegWidth-1:0] byp_addr_i,
    output logic                 byp_hit_o,
    output logic [XLen-1:0]      byp_data_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef struct packed {
        logic [NRegWidth-1:0] rd;
        logic [XLen-1:0]      data;
    } arb_entry_t;

    arb_entry_t                 push_entry;
    arb_entry_t                 head;
    arb_entry_t [Depth-1:0]     fifo_entries;
    logic       [PtrW-1:0]      fifo_rd_ptr;
    logic       [CntW-1:0]      fifo_count;
    logic                       push, pop, empty, full;
    logic                       lsu_xfer, alu_xfer;

    // Handshake and arbitration: LSU wins; rd==0 transfers are swallowed.
    always_comb begin
        lsu_ready_o = rst_ni && !full;
        alu_ready_o = rst_ni && !full && !lsu_valid_i;
        lsu_xfer    = lsu_valid_i && lsu_ready_o;
        alu_xfer    = alu_valid_i && alu_ready_o;
        push        = 1'b0;
        push_entry  = '0;
        if (lsu_xfer) begin
            push_entry.rd   = lsu_rd_i;
            push_entry.data = lsu_data_i;
            push            = (lsu_rd_i != '0);
        end else if (alu_xfer) begin
            push_entry.rd   = alu_rd_i;
            push_entry.data = alu_data_i;
            push            = (alu_rd_i != '0);
        end
    end

    // Write-port mux: debug owns the port, otherwise drain the queue head.
    always_comb begin
        a3_o  = '0;
        wd3_o = '0;
        we3_o = 1'b0;
        pop   = 1'b0;
        if (dbg_we_i) begin
            a3_o  = dbg_addr_i;
            wd3_o = dbg_data_i;
            we3_o = 1'b1;
        end else if (!empty) begin
            a3_o  = head.rd;
            wd3_o = head.data;
            we3_o = 1'b1;
            pop   = 1'b1;
        end
    end

    wb_fifo #(
        .entry_t (arb_entry_t),
        .Depth   (Depth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (empty),
        .full_o      (full),
        .entries_o   (fifo_entries),
        .rd_ptr_o    (fifo_rd_ptr),
        .count_o     (fifo_count)
    );

`ifdef WB_BYPASS_EN
    logic [PtrW-1:0] byp_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        byp_hit_o  = 1'b0;
        byp_data_o = '0;
        byp_idx    = '0;
        if (byp_addr_i != '0) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                byp_idx = fifo_rd_ptr + PtrW'(i);
                if ((CntW'(i) < fifo_count) && (fifo_entries[byp_idx].rd == byp_addr_i)) begin
                    byp_hit_o  = 1'b1;
                    byp_data_o = fifo_entries[byp_idx].data;
                end
            end
        end
    end
`else
    logic unused_byp;

    // Bypass not built: outputs tied off, search inputs intentionally unused.
    assign byp_hit_o  = 1'b0;
    assign byp_data_o = '0;
    assign unused_byp = ^{byp_addr_i, fifo_entries, fifo_rd_ptr, fifo_count};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default parameters).
// Inputs change and outputs are checked shortly after each falling edge.
module tb_regfile_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_valid_i, alu_valid_i, dbg_we_i;
    logic        lsu_ready_o, alu_ready_o;
    logic [4:0]  lsu_rd_i, alu_rd_i, dbg_addr_i, byp_addr_i, a3_o;
    logic [31:0] lsu_data_i, alu_data_i, dbg_data_i, wd3_o, byp_data_o;
    logic        we3_o, byp_hit_o;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_rd_i    (lsu_rd_i),
        .lsu_data_i  (lsu_data_i),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_data_i  (dbg_data_i),
        .a3_o        (a3_o),
        .we3_o       (we3_o),
        .wd3_o       (wd3_o),
        .byp_addr_i  (byp_addr_i),
        .byp_hit_o   (byp_hit_o),
        .byp_data_o  (byp_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    logic        exp_hit;
    logic [31:0] exp_b, exp_a;
    int          n;

    initial begin
`ifdef WB_BYPASS_EN
        exp_hit = 1'b1; exp_b = 32'hB; exp_a = 32'hA;
`else
        exp_hit = 1'b0; exp_b = 32'h0; exp_a = 32'h0;
`endif
        rst_ni = 1'b0;
        lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
        alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
        dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_data_i = '0;
        byp_addr_i = '0;

        // Reset state
        settle(); #1;
        chk("rst_we3", 32'(we3_o), 32'd0);
        chk("rst_lsu_rdy", 32'(lsu_ready_o), 32'd0);
        chk("rst_alu_rdy", 32'(alu_ready_o), 32'd0);
        chk("rst_byp_hit", 32'(byp_hit_o), 32'd0);
        dbg_we_i = 1'b1; dbg_addr_i = 5'd2; dbg_data_i = 32'h55; #1;
        chk("rst_dbg_we3", 32'(we3_o), 32'd1);
        chk("rst_dbg_a3", 32'(a3_o), 32'd2);
        settle();
        dbg_we_i = 1'b0; rst_ni = 1'b1; #1;
        chk("rel_lsu_rdy", 32'(lsu_ready_o), 32'd1);
        chk("rel_alu_rdy", 32'(alu_ready_o), 32'd1);
        chk("rel_we3", 32'(we3_o), 32'd0);

        // ALU single write
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF; #1;
        chk("alu1_same_we3", 32'(we3_o), 32'd0);
        settle();
        alu_valid_i = 1'b0; #1;
        chk("alu1_we3", 32'(we3_o), 32'd1);
        chk("alu1_a3", 32'(a3_o), 32'd5);
        chk("alu1_wd3", wd3_o, 32'hDEADBEEF);
        settle(); #1;
        chk("alu1_done_we3", 32'(we3_o), 32'd0);

        // LSU and ALU together: LSU first
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; lsu_data_i = 32'h11;
        alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = 32'h22; #1;
        chk("both_alu_rdy", 32'(alu_ready_o), 32'd0);
        chk("both_lsu_rdy", 32'(lsu_ready_o), 32'd1);
        settle();
        lsu_valid_i = 1'b0; #1;
        chk("both_w1_a3", 32'(a3_o), 32'd3);
        chk("both_w1_wd3", wd3_o, 32'h11);
        chk("both_w1_alu_rdy", 32'(alu_ready_o), 32'd1);
        settle();
        alu_valid_i = 1'b0; #1;
        chk("both_w2_we3", 32'(we3_o), 32'd1);
        chk("both_w2_a3", 32'(a3_o), 32'd4);
        chk("both_w2_wd3", wd3_o, 32'h22);
        settle(); #1;
        chk("both_done_we3", 32'(we3_o), 32'd0);

        // Debug stall while ALU fills the queue
        n = 0;
        dbg_addr_i = 5'd9; dbg_data_i = 32'h99;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) settle();
            dbg_we_i    = 1'b1;
            alu_valid_i = (n < 4);
            alu_rd_i    = 5'(n + 1);
            alu_data_i  = 32'h100 + 32'(n + 1);
            #1;
            chk($sformatf("stall%0d_alu_rdy", k), 32'(alu_ready_o), 32'(k < 4));
            chk($sformatf("stall%0d_lsu_rdy", k), 32'(lsu_ready_o), 32'(k < 4));
            chk($sformatf("stall%0d_a3", k), 32'(a3_o), 32'd9);
            chk($sformatf("stall%0d_wd3", k), wd3_o, 32'h99);
            if (k < 4) n++;
        end
        settle();
        dbg_we_i = 1'b0; alu_valid_i = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            if (j > 1) settle();
            #1;
            chk($sformatf("drain%0d_we3", j), 32'(we3_o), 32'd1);
            chk($sformatf("drain%0d_a3", j), 32'(a3_o), 32'(j));
            chk($sformatf("drain%0d_wd3", j), wd3_o, 32'h100 + 32'(j));
        end
        settle(); #1;
        chk("drain_done_we3", 32'(we3_o), 32'd0);

        // Bypass: two writes to rd 7 pending under debug stall
        dbg_we_i = 1'b1; dbg_addr_i = 5'd1; dbg_data_i = 32'h1;
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'hA; byp_addr_i = 5'd7; #1;
        chk("byp_empty_hit", 32'(byp_hit_o), 32'd0);
        settle();
        alu_data_i = 32'hB; #1;
        chk("byp_excl_hit", 32'(byp_hit_o), 32'(exp_hit));
        chk("byp_excl_data", byp_data_o, exp_a);
        settle();
        alu_valid_i = 1'b0; #1;
        chk("byp_hit", 32'(byp_hit_o), 32'(exp_hit));
        chk("byp_data", byp_data_o, exp_b);
        byp_addr_i = 5'd0; #1;
        chk("byp_zero_hit", 32'(byp_hit_o), 32'd0);
        byp_addr_i = 5'd8; #1;
        chk("byp_miss_hit", 32'(byp_hit_o), 32'd0);
        chk("byp_miss_data", byp_data_o, 32'd0);
        settle();
        dbg_we_i = 1'b0; byp_addr_i = 5'd7; #1;
        chk("byp_drainA_wd3", wd3_o, 32'hA);
        chk("byp_drainA_data", byp_data_o, exp_b);
        settle(); #1;
        chk("byp_drainB_wd3", wd3_o, 32'hB);
        chk("byp_drainB_a3", 32'(a3_o), 32'd7);
        settle(); #1;
        chk("byp_gone_hit", 32'(byp_hit_o), 32'd0);

        // rd==0 accepted but discarded
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFF; #1;
        chk("rd0_rdy", 32'(alu_ready_o), 32'd1);
        settle();
        alu_valid_i = 1'b0; #1;
        chk("rd0_we3", 32'(we3_o), 32'd0);
        settle(); #1;
        chk("rd0_we3_later", 32'(we3_o), 32'd0);

        // Reset with pending writes drops them
        dbg_we_i = 1'b1; dbg_addr_i = 5'd1; dbg_data_i = 32'h1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) settle();
            alu_valid_i = 1'b1; alu_rd_i = 5'(10 + k); alu_data_i = 32'h200 + 32'(k);
        end
        settle();
        alu_valid_i = 1'b0; dbg_we_i = 1'b0; byp_addr_i = 5'd10; rst_ni = 1'b0; #1;
        chk("mrst_we3", 32'(we3_o), 32'd0);
        chk("mrst_lsu_rdy", 32'(lsu_ready_o), 32'd0);
        chk("mrst_byp_hit", 32'(byp_hit_o), 32'd0);
        settle();
        rst_ni = 1'b1; #1;
        chk("mrel_we3", 32'(we3_o), 32'd0);
        chk("mrel_alu_rdy", 32'(alu_ready_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            settle(); #1;
            chk($sformatf("mrel_stale%0d_we3", k), 32'(we3_o), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
